// File: rtl/io_bus_master.sv
// io_bus_master: initiator for the memory-mapped IO bus between the CPU memory
// stage and the IO register file. Validates window/alignment, issues aligned
// 32-bit big-endian IO cycles, and performs read-modify-write for sub-word stores.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only when idle)
//   req_we/req_size/req_sign       store flag, size (byte/half/word), load sign-extension
//   req_addr/req_wdata             byte address, right-justified store data
//   resp_valid/resp_err/resp_rdata one-cycle completion pulse, reject flag, load result
//   io_ce/io_we/io_addr/io_wdata   IO slave strobe, direction, word address, write word
//   io_rdata                       IO slave read word (only meaningful during a read cycle)
module io_bus_master #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h400),
    parameter int unsigned       IO_SIZE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              io_ce,
    output logic              io_we,
    output logic [ADDR_W-1:0] io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [ADDR_W-1:0] IO_LAST = IO_BASE + ADDR_W'(IO_SIZE - 1);

    // Select the addressed big-endian lane and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: r = {{24{sign & b[7]}}, b};
            SZ_HALF: r = {{16{sign & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the low byte/half of the store data onto the addressed lane of the read word.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] w;
        w = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    w[31:24] = data[7:0];
                2'd1:    w[23:16] = data[7:0];
                2'd2:    w[15:8]  = data[7:0];
                default: w[7:0]   = data[7:0];
            endcase
        end else if (off[1]) begin
            w[15:0] = data;
        end else begin
            w[31:16] = data;
        end
        return w;
    endfunction

    logic [1:0]        state, state_nxt;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_sign;
    logic [1:0]        lat_off;
    logic [15:0]       lat_wdata;

    logic              req_ready_nxt, resp_valid_nxt, resp_err_nxt;
    logic [31:0]       resp_rdata_nxt;
    logic              io_ce_nxt, io_we_nxt;
    logic [ADDR_W-1:0] io_addr_nxt;
    logic [31:0]       io_wdata_nxt;

    logic              accept;
    logic              req_bad;

    assign accept = req_valid && req_ready;

    // Reject illegal size, misalignment, or an address outside the IO window.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = |req_addr[1:0];
            SZ_ILL:  req_bad = 1'b1;
            default: req_bad = 1'b1;
        endcase
        if ((req_addr < IO_BASE) || (req_addr > IO_LAST)) begin
            req_bad = 1'b1;
        end
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_nxt      = state;
        req_ready_nxt  = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = 32'd0;
        io_ce_nxt      = 1'b0;
        io_we_nxt      = 1'b0;
        io_addr_nxt    = '0;
        io_wdata_nxt   = 32'd0;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (accept) begin
                    req_ready_nxt = 1'b0;
                    if (req_bad) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_nxt    = WR;
                        io_ce_nxt    = 1'b1;
                        io_we_nxt    = 1'b1;
                        io_addr_nxt  = {req_addr[ADDR_W-1:2], 2'b00};
                        io_wdata_nxt = req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_nxt   = RD;
                        io_ce_nxt   = 1'b1;
                        io_addr_nxt = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            RD: begin
                if (lat_we) begin
                    state_nxt    = WR;
                    io_ce_nxt    = 1'b1;
                    io_we_nxt    = 1'b1;
                    io_addr_nxt  = io_addr;
                    io_wdata_nxt = merge_store(io_rdata, lat_wdata, lat_size, lat_off);
                end else begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = load_extract(io_rdata, lat_size, lat_off, lat_sign);
                end
            end
            WR: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
            end
            default: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, output and request-field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            io_ce      <= 1'b0;
            io_we      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= 32'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'd0;
            lat_sign   <= 1'b0;
            lat_off    <= 2'd0;
            lat_wdata  <= 16'd0;
        end else begin
            state      <= state_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            io_ce      <= io_ce_nxt;
            io_we      <= io_we_nxt;
            io_addr    <= io_addr_nxt;
            io_wdata   <= io_wdata_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_sign  <= req_sign;
                lat_off   <= req_addr[1:0];
                lat_wdata <= req_wdata[15:0];
            end
        end
    end

endmodule
